// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron with a Q2.16 membrane, a one-cycle
// post spike on threshold crossing, and a refractory period.
module lif_post_neuron #(
   parameter logic signed [17:0] V_TH       = 18'sh1_0000,
   parameter logic signed [17:0] V_RESET    = 18'sh0_0000,
   parameter logic signed [17:0] V_FLOOR    = 18'sh3_0000,
   parameter int unsigned        LEAK_SHIFT = 4,
   parameter int unsigned        T_REF      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        pre,
   input  logic [17:0] w,
   output logic        post,
   output logic [17:0] v,
   output logic        refr,
   output logic [15:0] spike_cnt
);

   typedef enum logic [1:0] {
      S_INTEG = 2'd0,
      S_FIRE  = 2'd1,
      S_REFR  = 2'd2
   } state_t;

   localparam logic signed [18:0] C_FLOOR = {V_FLOOR[17], V_FLOOR};
   localparam logic signed [18:0] C_VMAX  = 19'sh0_1FFFF;
   localparam logic [7:0]         C_TREF  = 8'(T_REF);

   state_t             r_state, w_state_nxt;
   logic signed [17:0] r_v, w_v_nxt;
   logic               r_post, w_post_nxt;
   logic [15:0]        r_cnt, w_cnt_nxt;
   logic [7:0]         r_ref, w_ref_nxt;

   logic signed [17:0] w_leak;
   logic signed [18:0] w_sum;
   logic signed [17:0] w_v_int;

   // Sum in 19 bits so the clamp sees the true value and never a wrapped one.
   always_comb begin
      w_leak = r_v >>> LEAK_SHIFT;
      w_sum  = $signed({r_v[17], r_v}) - $signed({w_leak[17], w_leak})
             + (pre ? $signed({w[17], w}) : 19'sh0);
      if (w_sum < C_FLOOR) begin
         w_v_int = V_FLOOR;
      end else if (w_sum > C_VMAX) begin
         w_v_int = 18'sh1_FFFF;
      end else begin
         w_v_int = w_sum[17:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_v_nxt     = r_v;
      w_post_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_ref_nxt   = r_ref;
      if (en) begin
         case (r_state)
            S_INTEG: begin
               w_v_nxt = w_v_int;
               if (w_v_int >= V_TH) begin
                  w_post_nxt  = 1'b1;
                  w_cnt_nxt   = r_cnt + 16'd1;
                  w_state_nxt = S_FIRE;
               end
            end
            S_FIRE: begin
               w_v_nxt = V_RESET;
               if (T_REF == 0) begin
                  w_state_nxt = S_INTEG;
               end else begin
                  w_ref_nxt   = C_TREF;
                  w_state_nxt = S_REFR;
               end
            end
            S_REFR: begin
               w_v_nxt   = V_RESET;
               w_ref_nxt = r_ref - 8'd1;
               if (r_ref == 8'd1) begin
                  w_state_nxt = S_INTEG;
               end
            end
            default: begin
               w_state_nxt = S_INTEG;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INTEG;
         r_v     <= V_RESET;
         r_post  <= 1'b0;
         r_cnt   <= '0;
         r_ref   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_v     <= w_v_nxt;
         r_post  <= w_post_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ref   <= w_ref_nxt;
      end
   end

   assign post      = r_post;
   assign v         = r_v;
   assign refr      = (r_state != S_INTEG);
   assign spike_cnt = r_cnt;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Scoreboard bench for lif_post_neuron: a behavioural model pushes expected outputs
// per driven cycle; each scenario task pops and compares after the edge.
module tb_lif_post_neuron;

   logic        clk;
   logic        rst;
   logic        en;
   logic        pre;
   logic [17:0] w;
   logic        post;
   logic [17:0] v;
   logic        refr;
   logic [15:0] spike_cnt;

   lif_post_neuron #(
      .V_TH       (18'sh1_0000),
      .V_RESET    (18'sh0_0000),
      .V_FLOOR    (18'sh3_0000),
      .LEAK_SHIFT (4),
      .T_REF      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .pre       (pre),
      .w         (w),
      .post      (post),
      .v         (v),
      .refr      (refr),
      .spike_cnt (spike_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        post;
      logic [17:0] v;
      logic        refr;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Behavioural model (0=INTEG, 1=FIRE, 2=REFR)
   int m_state = 0;
   int m_v     = 0;
   int m_ref   = 0;
   int m_cnt   = 0;
   bit m_post  = 1'b0;

   task automatic step(input logic r, input logic e, input logic p, input logic [17:0] wv);
      int s;
      int wi;
      exp_t ex;
      rst = r; en = e; pre = p; w = wv;
      wi = $signed(wv);
      if (r) begin
         m_state = 0; m_v = 0; m_post = 0; m_cnt = 0; m_ref = 0;
      end else if (!e) begin
         m_post = 0;
      end else if (m_state == 0) begin
         s = m_v - (m_v >>> 4) + (p ? wi : 0);
         if (s < -65536) s = -65536;
         if (s > 131071) s = 131071;
         m_v = s;
         if (s >= 65536) begin
            m_post = 1; m_cnt = (m_cnt + 1) & 16'hFFFF; m_state = 1;
         end else begin
            m_post = 0;
         end
      end else if (m_state == 1) begin
         m_post = 0; m_v = 0; m_ref = 8; m_state = 2;
      end else begin
         m_post = 0; m_v = 0;
         if (m_ref == 1) m_state = 0;
         m_ref = m_ref - 1;
      end
      ex.post = m_post;
      ex.v    = 18'(m_v);
      ex.refr = (m_state != 0);
      ex.cnt  = 16'(m_cnt);
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 18'h10000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e) begin
            n_fail++;
            $display("FAIL reset_sb: got %h expected %h", {post, v, refr, spike_cnt}, e);
         end
      end
      n_checks++;
      if (post !== 1'b0 || v !== 18'h0 || refr !== 1'b0 || spike_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_state: got post=%b v=%h refr=%b cnt=%h expected 0/00000/0/0000",
                  post, v, refr, spike_cnt);
      end
   endtask

   task automatic test_leak();
      exp_t e;
      logic [17:0] want [3];
      want[0] = 18'h08000; want[1] = 18'h07800; want[2] = 18'h07080;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, (i == 0), 18'h08000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e) begin
            n_fail++;
            $display("FAIL leak_sb[%0d]: got %h expected %h", i, {post, v, refr, spike_cnt}, e);
         end
         n_checks++;
         if (v !== want[i] || post !== 1'b0) begin
            n_fail++;
            $display("FAIL leak_v[%0d]: got v=%h post=%b expected v=%h post=0", i, v, post, want[i]);
         end
      end
   endtask

   task automatic test_fire();
      exp_t e;
      int n_refr;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      step(1'b0, 1'b1, 1'b1, 18'h10000);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || post !== 1'b1 || spike_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL fire_edge: got %h expected %h (post=1 cnt=1)", {post, v, refr, spike_cnt}, e);
      end
      n_refr = refr ? 1 : 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 1'b0, 18'h10000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e || post !== 1'b0 || v !== 18'h0) begin
            n_fail++;
            $display("FAIL fire_after[%0d]: got %h expected %h", i, {post, v, refr, spike_cnt}, e);
         end
         if (refr) n_refr++;
      end
      n_checks++;
      if (n_refr != 9 || refr !== 1'b0) begin
         n_fail++;
         $display("FAIL fire_refr_len: got %0d cycles (refr now %b) expected 9 then low", n_refr, refr);
      end
   endtask

   task automatic test_periodic();
      exp_t e;
      int last;
      last = -1;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 1'b1, 18'h10000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e) begin
            n_fail++;
            $display("FAIL periodic_sb[%0d]: got %h expected %h", i, {post, v, refr, spike_cnt}, e);
         end
         if (post === 1'b1) begin
            if (last >= 0) begin
               n_checks++;
               if (i - last != 10) begin
                  n_fail++;
                  $display("FAIL periodic_gap: got %0d expected 10", i - last);
               end
            end
            last = i;
         end
      end
      n_checks++;
      if (spike_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL periodic_cnt: got %0d expected 4", spike_cnt);
      end
   endtask

   task automatic test_floor();
      exp_t e;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 18'h20000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e || $signed(v) < $signed(18'h30000) || post !== 1'b0) begin
            n_fail++;
            $display("FAIL floor_sb[%0d]: got %h expected %h", i, {post, v, refr, spike_cnt}, e);
         end
      end
      n_checks++;
      if (v !== 18'h30000) begin
         n_fail++;
         $display("FAIL floor_v: got %h expected 30000", v);
      end
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      step(1'b0, 1'b1, 1'b1, 18'h3FFFF);
      e = sb_q.pop_front();
      step(1'b0, 1'b1, 1'b0, 18'h0);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || v !== 18'h0) begin
         n_fail++;
         $display("FAIL neg_leak: got v=%h expected 00000", v);
      end
   endtask

   task automatic test_clamp_high();
      exp_t e;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      step(1'b0, 1'b1, 1'b1, 18'h0F000);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || v !== 18'h0F000 || post !== 1'b0) begin
         n_fail++;
         $display("FAIL high_pre: got v=%h post=%b expected v=0f000 post=0", v, post);
      end
      step(1'b0, 1'b1, 1'b1, 18'h1FFFF);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || v !== 18'h1FFFF || post !== 1'b1) begin
         n_fail++;
         $display("FAIL high_clamp: got v=%h post=%b expected v=1ffff post=1", v, post);
      end
   endtask

   task automatic test_freeze();
      exp_t e;
      int n_refr;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      step(1'b0, 1'b1, 1'b1, 18'h10000);
      void'(sb_q.pop_front());
      n_refr = refr ? 1 : 0;
      for (int i = 0; i < 21; i++) begin
         if (i >= 3 && i < 6) step(1'b0, 1'b0, 1'b1, 18'h1FFFF);
         else                 step(1'b0, 1'b1, (i < 3), 18'h10000);
         e = sb_q.pop_front();
         n_checks++;
         if ({post, v, refr, spike_cnt} !== e) begin
            n_fail++;
            $display("FAIL freeze_sb[%0d]: got %h expected %h", i, {post, v, refr, spike_cnt}, e);
         end
         if (i >= 3 && i < 6) begin
            n_checks++;
            if (v !== 18'h0 || refr !== 1'b1 || post !== 1'b0 || spike_cnt !== 16'd1) begin
               n_fail++;
               $display("FAIL freeze_hold[%0d]: got v=%h refr=%b post=%b cnt=%0d expected 0/1/0/1",
                        i, v, refr, post, spike_cnt);
            end
         end
         if (refr) n_refr++;
      end
      n_checks++;
      if (n_refr != 12) begin
         n_fail++;
         $display("FAIL freeze_refr_len: got %0d expected 12", n_refr);
      end
   endtask

   task automatic test_rst_fire();
      exp_t e;
      step(1'b1, 1'b1, 1'b0, 18'h0);
      void'(sb_q.pop_front());
      step(1'b0, 1'b1, 1'b1, 18'h10000);
      void'(sb_q.pop_front());
      step(1'b1, 1'b1, 1'b1, 18'h10000);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || post !== 1'b0 || spike_cnt !== 16'd0 || refr !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_fire: got post=%b cnt=%0d refr=%b expected 0/0/0", post, spike_cnt, refr);
      end
      step(1'b0, 1'b1, 1'b0, 18'h0);
      e = sb_q.pop_front();
      n_checks++;
      if ({post, v, refr, spike_cnt} !== e || v !== 18'h0) begin
         n_fail++;
         $display("FAIL rst_fire_after: got %h expected %h", {post, v, refr, spike_cnt}, e);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pre = 1'b0; w = '0;
      #1;
      test_reset();
      test_leak();
      test_fire();
      test_periodic();
      test_floor();
      test_clamp_high();
      test_freeze();
      test_rst_fire();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
